data_mem_stage: RTL and testbench
=================================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width of memory and data ports.
REQ-002 SHALL have parameter ADDR_W, default 64, width of address-carrying inputs and mem_add.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; legal word index 0..DEPTH-1.
REQ-004 SHALL have parameter INIT_WORDS, default 21, count of words preloaded at time zero with mem[i]=i.
REQ-005 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  access request present this cycle.
REQ-008 SHALL have port in_code  input  4  instruction code selecting the access type.
REQ-009 SHALL have ports val_e, val_a  input  ADDR_W/DATA_W  execute result and register A value.
REQ-010 SHALL have port val_p  input  DATA_W  next-PC value, the write data for call.
REQ-011 SHALL have port resp_valid  output  1  one-cycle pulse marking a completed request.
REQ-012 SHALL have port val_m  output  DATA_W  read data.
REQ-013 SHALL have ports mem_add (ADDR_W) and mem_data (DATA_W)  output  address used by the last access and word at that address after the access.
REQ-014 SHALL have port bad_mem  output  1  address error for the completed request (pulse).
REQ-015 SHALL have port bad_mem_sticky  output  1  set on any error, cleared only by reset.
REQ-016 SHALL have port wr_count  output  16  count of committed writes, wraps at 16'hFFFF->0.

Function
REQ-017 SHALL decode: 5 read @val_e; 9 and 11 read @val_a; 4 and 10 write val_a @val_e; 8 write val_p @val_e; all other codes perform no access.
REQ-018 SHALL accept a request on every rising edge where req_valid=1; no backpressure; one request per cycle sustained.
REQ-019 SHALL commit a write on the accepting edge; the array is untouched when req_valid=0.
REQ-020 SHALL assert resp_valid exactly one cycle after acceptance, for one cycle, for every accepted request including no-access codes.
REQ-021 SHALL present val_m for a read in the resp_valid cycle (latency 1); val_m SHALL hold its previous value for writes and no-access codes.
REQ-022 SHALL update mem_add to the access address and mem_data to the post-access word at that address in the resp_valid cycle; both SHALL hold for no-access codes.
REQ-023 SHALL treat an address as bad when it is >= DEPTH, compared over the full ADDR_W bits with no truncation.
REQ-024 SHALL, for a bad address: suppress the write, leave val_m unchanged, load mem_data with 0, set mem_add to the bad address, pulse bad_mem with resp_valid, and set bad_mem_sticky.
REQ-025 SHALL return the newly written data to a read of the same address accepted on the following edge (no stale read).
REQ-026 SHALL increment wr_count on each committed (non-suppressed) write only.
REQ-027 SHALL implement a two-state pipeline flag: IDLE (no response pending) -> PEND on accept; PEND -> PEND on back-to-back accept; PEND -> IDLE otherwise.

Reset
REQ-028 SHALL, on reset assertion, immediately clear resp_valid, bad_mem, bad_mem_sticky, val_m, mem_add, mem_data, and wr_count to 0, and force IDLE.
REQ-029 SHALL drop any response pending at reset; no resp_valid SHALL appear for a request accepted before or during reset.
REQ-030 SHALL ignore req_valid while reset is high, and accept again on the first rising edge after deassertion.
REQ-031 SHALL leave memory contents unaffected by reset; preload (REQ-004) applies only at time zero.

Verification
REQ-032 SHALL pass: read code 5, val_e=7 after preload -> next cycle resp_valid=1, val_m=7, mem_add=7, bad_mem=0.
REQ-033 SHALL pass: code 4, val_e=3, val_a=64'hAA, then code 5, val_e=3 on the next edge -> second response val_m=64'hAA, wr_count=1.
REQ-034 SHALL pass: code 8, val_e=1024, val_p=5 -> bad_mem pulse, sticky=1, mem_data=0, wr_count unchanged; a later read of 1023 returns the preloaded or last-written value.
REQ-035 SHALL pass: code 11, val_a=2, then code 3 -> val_m=2, then a second resp_valid with val_m still 2 and mem_add still 2.
REQ-036 SHALL pass: reset asserted mid-cycle after an accept -> outputs 0 immediately, no resp_valid afterwards, mem[3] retains its written value.

Source files
------------

// File: rtl/data_mem_stage.sv
// Memory-access pipeline stage: decodes the access type, performs a single-cycle read or write
// on a word array, and returns a registered response one cycle later with address-error flags.
module data_mem_stage #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned INIT_WORDS = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [3:0]        in_code,
  input  logic [ADDR_W-1:0] val_e,
  input  logic [DATA_W-1:0] val_a,
  input  logic [DATA_W-1:0] val_p,
  output logic              resp_valid,
  output logic [DATA_W-1:0] val_m,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_data,
  output logic              bad_mem,
  output logic              bad_mem_sticky,
  output logic [15:0]       wr_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TIW   = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  // Words below INIT_WORDS read back their own index until first written.
  logic [(1<<TIW)-1:0] touched = '0;

  logic              acc_rd, acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_bad, in_init;
  logic [IDX_W-1:0]  idx;
  logic [TIW-1:0]    tidx;
  logic [DATA_W-1:0] rd_word;
  logic              good_rd, good_wr, bad_acc;

  // Access decode.
  always_comb begin
    acc_rd   = 1'b0;
    acc_wr   = 1'b0;
    acc_addr = '0;
    wdata    = '0;
    case (in_code)
      4'd5: begin
        acc_rd   = 1'b1;
        acc_addr = val_e;
      end
      4'd9, 4'd11: begin
        acc_rd   = 1'b1;
        acc_addr = ADDR_W'(val_a);
      end
      4'd4, 4'd10: begin
        acc_wr   = 1'b1;
        acc_addr = val_e;
        wdata    = val_a;
      end
      4'd8: begin
        acc_wr   = 1'b1;
        acc_addr = val_e;
        wdata    = val_p;
      end
      default: ;
    endcase
  end

  assign addr_bad = (acc_addr >= ADDR_W'(DEPTH));
  assign idx      = acc_addr[IDX_W-1:0];
  assign tidx     = TIW'(idx);
  assign in_init  = (32'(idx) < INIT_WORDS);
  assign rd_word  = (in_init && !touched[tidx]) ? DATA_W'(idx) : mem[idx];
  assign good_rd  = req_valid && acc_rd && !addr_bad;
  assign good_wr  = req_valid && acc_wr && !addr_bad;
  assign bad_acc  = req_valid && (acc_rd || acc_wr) && addr_bad;

  // Array write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && good_wr) begin
      mem[idx] <= wdata;
      if (in_init) touched[tidx] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (req_valid) state_d = PEND;
      PEND:    if (req_valid) state_d = PEND;
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid = (state_q == PEND);

  // Response registers, loaded on the accepting edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_m          <= '0;
      mem_add        <= '0;
      mem_data       <= '0;
      bad_mem        <= 1'b0;
      bad_mem_sticky <= 1'b0;
      wr_count       <= '0;
    end else begin
      bad_mem <= bad_acc;
      if (bad_acc) begin
        bad_mem_sticky <= 1'b1;
        mem_add        <= acc_addr;
        mem_data       <= '0;
      end else if (good_rd) begin
        val_m    <= rd_word;
        mem_add  <= acc_addr;
        mem_data <= rd_word;
      end else if (good_wr) begin
        mem_add  <= acc_addr;
        mem_data <= wdata;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: reads, writes, bad addresses, no-access codes and
// mid-cycle reset, with hand-computed expectations.
module tb_data_mem_stage;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [3:0]  in_code;
  logic [63:0] val_e, val_a, val_p;
  logic        resp_valid;
  logic [63:0] val_m, mem_add, mem_data;
  logic        bad_mem, bad_mem_sticky;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_stage dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .in_code        (in_code),
    .val_e          (val_e),
    .val_a          (val_a),
    .val_p          (val_p),
    .resp_valid     (resp_valid),
    .val_m          (val_m),
    .mem_add        (mem_add),
    .mem_data       (mem_data),
    .bad_mem        (bad_mem),
    .bad_mem_sticky (bad_mem_sticky),
    .wr_count       (wr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drives one cycle of inputs and returns at the next negedge.
  task automatic cyc(input logic v, input logic [3:0] c, input logic [63:0] e,
                     input logic [63:0] a, input logic [63:0] p);
    req_valid = v;
    in_code   = c;
    val_e     = e;
    val_a     = a;
    val_p     = p;
    @(negedge clock);
  endtask

  task automatic resp(input string tag, input logic rv, input logic [63:0] vm,
                      input logic [63:0] ad, input logic [63:0] dt, input logic bm,
                      input logic st, input logic [15:0] wc);
    check({tag, ".resp_valid"}, 64'(resp_valid), 64'(rv));
    check({tag, ".val_m"}, val_m, vm);
    check({tag, ".mem_add"}, mem_add, ad);
    check({tag, ".mem_data"}, mem_data, dt);
    check({tag, ".bad_mem"}, 64'(bad_mem), 64'(bm));
    check({tag, ".sticky"}, 64'(bad_mem_sticky), 64'(st));
    check({tag, ".wr_count"}, 64'(wr_count), 64'(wc));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; in_code = '0; val_e = '0; val_a = '0; val_p = '0;
    repeat (3) @(negedge clock);
    resp("in_reset", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    cyc(1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    resp("after_reset", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 16'd0);

    cyc(1'b1, 4'd5, 64'd7, 64'h0, 64'h0);
    resp("rd7", 1'b1, 64'd7, 64'd7, 64'd7, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd4, 64'd3, 64'hAA, 64'h0);
    resp("wr3", 1'b1, 64'd7, 64'd3, 64'hAA, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 4'd5, 64'd3, 64'h0, 64'h0);
    resp("rd3_b2b", 1'b1, 64'hAA, 64'd3, 64'hAA, 1'b0, 1'b0, 16'd1);
    cyc(1'b0, 4'd5, 64'd9, 64'h0, 64'h0);
    resp("idle", 1'b0, 64'hAA, 64'd3, 64'hAA, 1'b0, 1'b0, 16'd1);

    cyc(1'b1, 4'd10, 64'd1023, 64'h55, 64'h0);
    resp("wr1023", 1'b1, 64'hAA, 64'd1023, 64'h55, 1'b0, 1'b0, 16'd2);
    cyc(1'b1, 4'd8, 64'd1024, 64'h0, 64'd5);
    resp("bad1024", 1'b1, 64'hAA, 64'd1024, 64'h0, 1'b1, 1'b1, 16'd2);
    cyc(1'b1, 4'd5, 64'd1023, 64'h0, 64'h0);
    resp("rd1023", 1'b1, 64'h55, 64'd1023, 64'h55, 1'b0, 1'b1, 16'd2);
    cyc(1'b1, 4'd5, 64'h8000_0000_0000_0005, 64'h0, 64'h0);
    resp("bad_hi", 1'b1, 64'h55, 64'h8000_0000_0000_0005, 64'h0, 1'b1, 1'b1, 16'd2);

    cyc(1'b1, 4'd11, 64'h0, 64'd2, 64'h0);
    resp("rd_a2", 1'b1, 64'd2, 64'd2, 64'd2, 1'b0, 1'b1, 16'd2);
    cyc(1'b1, 4'd3, 64'd77, 64'd88, 64'h0);
    resp("noacc", 1'b1, 64'd2, 64'd2, 64'd2, 1'b0, 1'b1, 16'd2);
    cyc(1'b1, 4'd9, 64'h0, 64'd20, 64'h0);
    resp("rd_a20", 1'b1, 64'd20, 64'd20, 64'd20, 1'b0, 1'b1, 16'd2);
    cyc(1'b1, 4'd8, 64'd4, 64'h0, 64'h1234);
    resp("call4", 1'b1, 64'd20, 64'd4, 64'h1234, 1'b0, 1'b1, 16'd3);
    cyc(1'b1, 4'd5, 64'd4, 64'h0, 64'h0);
    resp("rd4", 1'b1, 64'h1234, 64'd4, 64'h1234, 1'b0, 1'b1, 16'd3);

    // Accept a write, then reset in the middle of the following cycle.
    req_valid = 1'b1; in_code = 4'd4; val_e = 64'd3; val_a = 64'hBEEF;
    @(posedge clock);
    #2 reset = 1'b1;
    #1 resp("mid_reset", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 16'd0);
    val_a = 64'hDEAD;
    @(negedge clock);
    check("in_reset1.resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clock);
    check("in_reset2.resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    cyc(1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    resp("post_reset", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd5, 64'd3, 64'h0, 64'h0);
    resp("rd3_kept", 1'b1, 64'hBEEF, 64'd3, 64'hBEEF, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    check("final.resp_valid", 64'(resp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
